data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory behind a req/busy/ready_n
// handshake. Loads complete after RD_LAT cycles, stores hold busy for WR_LAT.
// Optional build macro DMEM_ALIGN_CHECK_EN adds the derr output and rejects
// misaligned accesses; without it low address bits are masked to alignment.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [1:0]  dsize,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata,
  output logic [31:0] mem_rdata,
  output logic        dready_n,
  output logic        dbusy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        derr
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] RD_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_BUSY} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic [31:0]   rdata_q;
  logic          dready_n_q;
  logic          dbusy_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic          derr_q;
`endif

  logic [31:0] mem [DEPTH_WORDS];

  // Address bits above the array index alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^daddr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction
`endif

  // Read path: in IDLE the live request is used (RD_LAT=1 captures at the
  // accept edge); otherwise the latched address/size.
  logic [AW+1:0] rd_addr;
  logic [1:0]    rd_size;
  logic [31:0]   rd_word;
  logic [31:0]   rd_elem;
  logic [31:0]   rd_data;
  logic          rd_err;

  // Select address and extract the right-justified, zero-extended element.
  always_comb begin
    rd_addr = (state_q == IDLE) ? daddr[AW+1:0] : addr_q;
    rd_size = (state_q == IDLE) ? dsize : size_q;
    rd_word = mem[rd_addr[AW+1:2]];
    case (rd_size)
      2'b00:   rd_elem = {24'd0, rd_word[8*rd_addr[1:0] +: 8]};
      2'b01:   rd_elem = {16'd0, rd_word[16*rd_addr[1] +: 16]};
      default: rd_elem = rd_word;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    rd_err  = misaligned(rd_size, rd_addr[1:0]);
    rd_data = rd_err ? 32'd0 : rd_elem;
`else
    rd_err  = 1'b0;
    rd_data = rd_elem;
`endif
  end

  // Write path: byte enables and lane-replicated data for the store element.
  logic        wr_en;
  logic        wr_err;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  // Decode store acceptance and lane mapping.
  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    wr_err = misaligned(dsize, daddr[1:0]);
`else
    wr_err = 1'b0;
`endif
    wr_en = rst && (state_q == IDLE) && dreq && dwrite && !wr_err;
    case (dsize)
      2'b00: begin
        wr_be   = 4'b0001 << daddr[1:0];
        wr_data = {4{ddata[7:0]}};
      end
      2'b01: begin
        wr_be   = daddr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{ddata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = ddata;
      end
    endcase
  end

  // Array write at the store-accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[daddr[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      rdata_q    <= 32'd0;
      dready_n_q <= 1'b1;
      dbusy_q    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      derr_q     <= 1'b0;
`endif
    end else begin
`ifdef DMEM_ALIGN_CHECK_EN
      derr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (dreq) begin
            dbusy_q <= 1'b1;
            if (dwrite) begin
              state_q <= WR_BUSY;
              cnt_q   <= WR_INIT;
`ifdef DMEM_ALIGN_CHECK_EN
              derr_q  <= wr_err;
`endif
            end else begin
              addr_q <= daddr[AW+1:0];
              size_q <= dsize;
              if (RD_LAT == 1) begin
                state_q    <= RD_DONE;
                dready_n_q <= 1'b0;
                rdata_q    <= rd_data;
`ifdef DMEM_ALIGN_CHECK_EN
                derr_q     <= rd_err;
`endif
              end else begin
                state_q <= RD_WAIT;
                cnt_q   <= RD_INIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q    <= RD_DONE;
            dready_n_q <= 1'b0;
            rdata_q    <= rd_data;
`ifdef DMEM_ALIGN_CHECK_EN
            derr_q     <= rd_err;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_DONE: begin
          state_q    <= IDLE;
          dready_n_q <= 1'b1;
          dbusy_q    <= 1'b0;
        end
        WR_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            dbusy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          dready_n_q <= 1'b1;
          dbusy_q    <= 1'b0;
        end
      endcase
    end
  end

  // rd_err only feeds derr in the checking build.
  logic unused_rd_err;
  assign unused_rd_err = rd_err;

  assign mem_rdata = rdata_q;
  assign dready_n  = dready_n_q;
  assign dbusy     = dbusy_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign derr      = derr_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus a randomized
// load/store mix scored against a byte-addressed memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int RDL   = 2;
  localparam int WRL   = 3;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dreq = 1'b0;
  logic        dwrite = 1'b0;
  logic [1:0]  dsize = 2'b00;
  logic [31:0] daddr = 32'd0;
  logic [31:0] ddata = 32'd0;
  logic [31:0] mem_rdata;
  logic        dready_n;
  logic        dbusy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        derr;
`endif

  int checks   = 0;
  int failures = 0;

  // Byte-level model of the 4 KiB array (address bits above 11 alias).
  logic [7:0] mdl [0:4095];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .RD_LAT(RDL), .WR_LAT(WRL)) dut (
    .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .dsize(dsize),
    .daddr(daddr), .ddata(ddata), .mem_rdata(mem_rdata),
    .dready_n(dready_n), .dbusy(dbusy)
`ifdef DMEM_ALIGN_CHECK_EN
    , .derr(derr)
`endif
  );

  function automatic logic get_derr();
`ifdef DMEM_ALIGN_CHECK_EN
    return derr;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return a;
    if (s == 2'b01) return {a[31:1], 1'b0};
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic misal(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return 1'b0;
    if (s == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic void mdl_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] b;
    if (ALIGN && misal(a, s)) return;
    b = base_of(a, s);
    for (int i = 0; i < nbytes(s); i++) mdl[12'(b + 32'(i))] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] b, r;
    r = 32'd0;
    if (ALIGN && misal(a, s)) return r;
    b = base_of(a, s);
    for (int i = 0; i < nbytes(s); i++) r[8*i +: 8] = mdl[12'(b + 32'(i))];
    return r;
  endfunction

  // Bounded wait for the responder to report not-busy.
  task automatic wait_idle();
    int n = 0;
    while (dbusy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_idle: dbusy=%b still, required 0", dbusy);
    end
  endtask

  // Issue one store; report busy length and derr activity.
  task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                          output int busy, output logic e_first, output int errcyc);
    wait_idle();
    dreq = 1'b1; dwrite = 1'b1; daddr = a; dsize = s; ddata = d;
    @(posedge clk); #1;
    dreq = 1'b0; daddr = $urandom; ddata = $urandom;
    mdl_store(a, s, d);
    e_first = get_derr();
    busy = 0; errcyc = 0;
    while (dbusy === 1'b1 && busy < 40) begin
      if (get_derr() === 1'b1) errcyc++;
      busy++;
      @(posedge clk); #1;
    end
  endtask

  // Issue one load; lat counts cycles with the request cycle as cycle 0.
  task automatic do_load(input logic [31:0] a, input logic [1:0] s,
                         output logic [31:0] d, output int lat, output logic e, output logic held);
    wait_idle();
    dreq = 1'b1; dwrite = 1'b0; daddr = a; dsize = s; ddata = $urandom;
    @(posedge clk); #1;
    dreq = 1'b0; daddr = $urandom; dsize = 2'($urandom);
    lat = 1;
    while (dready_n !== 1'b0 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    d = mem_rdata; e = get_derr();
    @(posedge clk); #1;
    held = (dready_n === 1'b1) && (mem_rdata === d);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dready_n !== 1'b1 || dbusy !== 1'b0 || mem_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset: dready_n=%b dbusy=%b rdata=%h, required 1 0 00000000", dready_n, dbusy, mem_rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic preload();
    int b, f; logic e;
    for (int i = 0; i < DEPTH; i++) do_store(32'(i * 4), 2'b10, $urandom, b, e, f);
  endtask

  task automatic test_word();
    int b, f, lat; logic e, h; logic [31:0] d;
    do_store(32'h100, 2'b10, 32'hDEADBEEF, b, e, f);
    checks++;
    if (b !== WRL) begin failures++; $display("FAIL word_store_busy: got %0d cycles, required %0d", b, WRL); end
    do_load(32'h100, 2'b10, d, lat, e, h);
    checks++;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load: got %h, required deadbeef", d); end
    checks++;
    if (lat !== RDL) begin failures++; $display("FAIL word_latency: got %0d, required %0d", lat, RDL); end
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL ready_pulse_hold: got %b, required 1", h); end
  endtask

  task automatic test_byte_half();
    int b, f, lat; logic e, h; logic [31:0] d;
    do_store(32'h101, 2'b00, 32'hFFFFFF5A, b, e, f);
    do_store(32'h102, 2'b01, 32'hFFFF1234, b, e, f);
    do_load(32'h100, 2'b10, d, lat, e, h);
    checks++;
    if (d !== 32'h12345AEF) begin failures++; $display("FAIL merge_word: got %h, required 12345aef", d); end
    do_load(32'h103, 2'b00, d, lat, e, h);
    checks++;
    if (d !== 32'h00000012) begin failures++; $display("FAIL byte_load: got %h, required 00000012", d); end
    do_load(32'h102, 2'b01, d, lat, e, h);
    checks++;
    if (d !== 32'h00001234) begin failures++; $display("FAIL half_load: got %h, required 00001234", d); end
  endtask

  task automatic test_back_to_back();
    int busy, lat; logic rdy_seen; logic [31:0] d;
    wait_idle();
    dreq = 1'b1; dwrite = 1'b1; daddr = 32'h200; dsize = 2'b10; ddata = 32'h0BADF00D;
    @(posedge clk); #1;
    mdl_store(32'h200, 2'b10, 32'h0BADF00D);
    dwrite = 1'b0; ddata = $urandom;           // load request held from the next cycle
    busy = 0; rdy_seen = 1'b0;
    while (dbusy === 1'b1 && busy < 40) begin
      if (dready_n === 1'b0) rdy_seen = 1'b1;
      busy++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== WRL) begin failures++; $display("FAIL b2b_busy: got %0d cycles, required %0d", busy, WRL); end
    checks++;
    if (rdy_seen !== 1'b0) begin failures++; $display("FAIL b2b_early_ready: got %b, required 0", rdy_seen); end
    @(posedge clk); #1;                        // accept edge for the held load
    dreq = 1'b0;
    lat = 1;
    while (dready_n !== 1'b0 && lat < 40) begin @(posedge clk); #1; lat++; end
    d = mem_rdata;
    checks++;
    if (lat !== RDL || d !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL b2b_load: got lat=%0d data=%h, required lat=%0d data=0badf00d", lat, d, RDL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    int lat; logic e, h, rdy_seen; logic [31:0] d;
    wait_idle();
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h100; dsize = 2'b10;
    @(posedge clk); #1;
    dreq = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (dready_n !== 1'b1 || dbusy !== 1'b0 || mem_rdata !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset: dready_n=%b dbusy=%b rdata=%h, required 1 0 00000000", dready_n, dbusy, mem_rdata);
    end
    rdy_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dready_n !== 1'b1) rdy_seen = 1'b1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (dready_n !== 1'b1) rdy_seen = 1'b1;
    end
    checks++;
    if (rdy_seen !== 1'b0) begin failures++; $display("FAIL abandoned_load_pulse: got %b, required 0", rdy_seen); end
    do_load(32'h100, 2'b10, d, lat, e, h);
    checks++;
    if (d !== 32'h12345AEF) begin failures++; $display("FAIL array_kept: got %h, required 12345aef", d); end
  endtask

  task automatic test_alias();
    int b, f, lat; logic e, h; logic [31:0] d;
    do_store(32'h00001000, 2'b10, 32'hA5A5A5A5, b, e, f);
    do_load(32'h00000000, 2'b10, d, lat, e, h);
    checks++;
    if (d !== 32'hA5A5A5A5) begin failures++; $display("FAIL alias: got %h, required a5a5a5a5", d); end
  endtask

  task automatic test_align();
    int b, f, lat; logic e, h; logic [31:0] d;
`ifdef DMEM_ALIGN_CHECK_EN
    do_store(32'h102, 2'b10, 32'hCAFEF00D, b, e, f);
    checks++;
    if (e !== 1'b1 || f !== 1) begin failures++; $display("FAIL mis_store_derr: first=%b cycles=%0d, required 1 1", e, f); end
    do_load(32'h100, 2'b10, d, lat, e, h);
    checks++;
    if (d !== 32'h12345AEF) begin failures++; $display("FAIL mis_store_unchanged: got %h, required 12345aef", d); end
    do_load(32'h101, 2'b01, d, lat, e, h);
    checks++;
    if (d !== 32'd0 || e !== 1'b1 || lat !== RDL) begin
      failures++;
      $display("FAIL mis_load: data=%h derr=%b lat=%0d, required 00000000 1 %0d", d, e, lat, RDL);
    end
`else
    b = 0; f = 0;
    do_load(32'h101, 2'b01, d, lat, e, h);
    checks++;
    if (d !== 32'h00005AEF) begin failures++; $display("FAIL mask_half: got %h, required 00005aef", d); end
    do_load(32'h102, 2'b10, d, lat, e, h);
    checks++;
    if (d !== 32'h12345AEF) begin failures++; $display("FAIL mask_word: got %h, required 12345aef", d); end
`endif
  endtask

  task automatic test_random();
    int b, f, lat; logic e, h; logic [31:0] a, d, exp; logic [1:0] s; logic me;
    for (int n = 0; n < 200; n++) begin
      a = $urandom; s = 2'($urandom_range(0, 3)); me = ALIGN && misal(a, s);
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, s, $urandom, b, e, f);
        checks++;
        if (b !== WRL || e !== me) begin
          failures++;
          $display("FAIL rnd_store a=%h s=%0d: busy=%0d derr=%b, required %0d %b", a, s, b, e, WRL, me);
        end
      end else begin
        exp = mdl_load(a, s);
        do_load(a, s, d, lat, e, h);
        checks++;
        if (d !== exp || lat !== RDL || e !== me || h !== 1'b1) begin
          failures++;
          $display("FAIL rnd_load a=%h s=%0d: data=%h lat=%0d derr=%b hold=%b, required %h %0d %b 1",
                   a, s, d, lat, e, h, exp, RDL, me);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_word();
    test_byte_half();
    test_back_to_back();
    test_reset_mid_load();
    test_alias();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
